// File: rtl/tt_scan_ctrl_pkg.sv
// Shared types and defaults for the truth-table scan sequencer.
package tt_scan_ctrl_pkg;

    localparam int N_IN_DEF   = 4;
    localparam int SETTLE_DEF = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/tt_scan_ctrl_if.sv
// Bus between the scan sequencer and its client: start/expected in, vector drive out,
// function output back in, results out.
interface tt_scan_ctrl_if import tt_scan_ctrl_pkg::*; #(
    parameter int N_IN = N_IN_DEF
);
    localparam int W = 1 << N_IN;

    logic              start;
    logic [W-1:0]      expected;
    logic [N_IN-1:0]   vec;
    logic              f_in;
    logic              busy;
    logic              done;
    logic [W-1:0]      table_out;
    logic              match;
    logic [N_IN:0]     ones_count;

    modport master (
        output start, expected, f_in,
        input  vec, busy, done, table_out, match, ones_count
    );

    modport slave (
        input  start, expected, f_in,
        output vec, busy, done, table_out, match, ones_count
    );

endinterface

// File: rtl/tt_settle_timer.sv
// Down-counter timing how long each vector is held; latency 0 (zero_o decodes the register).
// Load has priority over decrement; decrement saturates at zero.
module tt_settle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       dec_i,
    output logic       zero_o
);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/tt_scan_ctrl.sv
// Sweeps all input vectors of a combinational function, builds its truth table and checks it.
// Done arrives 16*(SETTLE+1) edges after start acceptance; start is ignored while busy.
module tt_scan_ctrl import tt_scan_ctrl_pkg::*; #(
    parameter int N_IN   = N_IN_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic           clk,
    input  logic           rst,
    tt_scan_ctrl_if.slave  scan_if
);

    localparam int              W         = 1 << N_IN;
    localparam logic [N_IN-1:0] VEC_LAST  = '1;
    localparam logic [3:0]      SETTLE_LD = 4'(SETTLE - 1);

    function automatic logic [N_IN:0] popcount(input logic [W-1:0] t);
        logic [N_IN:0] n;
        n = '0;
        for (int i = 0; i < W; i++) begin
            n = n + {{N_IN{1'b0}}, t[i]};
        end
        return n;
    endfunction

    state_t          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [W-1:0]    table_q, table_d;
    logic [W-1:0]    exp_q, exp_d;
    logic            match_q, match_d;
    logic [N_IN:0]   ones_q, ones_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            tmr_load, tmr_dec, tmr_zero;

    tt_settle_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (SETTLE_LD),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        table_d  = table_q;
        exp_d    = exp_q;
        match_d  = match_q;
        ones_d   = ones_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (scan_if.start) begin
                    state_d  = ST_APPLY;
                    vec_d    = '0;
                    table_d  = '0;
                    match_d  = 1'b0;
                    ones_d   = '0;
                    exp_d    = scan_if.expected;
                    tmr_load = 1'b1;
                end
            end
            ST_APPLY: begin
                if (tmr_zero) begin
                    state_d = ST_SAMPLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_SAMPLE: begin
                table_d[vec_q] = scan_if.f_in;
                // Results are computed from the completed table so they are valid with done.
                if (vec_q == VEC_LAST) begin
                    state_d = ST_DONE;
                    match_d = (table_d == exp_q);
                    ones_d  = popcount(table_d);
                end else begin
                    state_d  = ST_APPLY;
                    vec_d    = vec_q + N_IN'(1);
                    tmr_load = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                vec_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            table_q <= '0;
            exp_q   <= '0;
            match_q <= 1'b0;
            ones_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            table_q <= table_d;
            exp_q   <= exp_d;
            match_q <= match_d;
            ones_q  <= ones_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign scan_if.vec        = vec_q;
    assign scan_if.table_out  = table_q;
    assign scan_if.match      = match_q;
    assign scan_if.ones_count = ones_q;
    assign scan_if.busy       = busy_q;
    assign scan_if.done       = done_q;

endmodule

// File: tb/tb_tt_scan_ctrl.sv
// Directed plus randomized bench for tt_scan_ctrl with SETTLE=1 and SETTLE=3 instances.
`timescale 1ns/1ps
module tb_tt_scan_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    tt_scan_ctrl_if #(.N_IN(4)) ifa ();
    tt_scan_ctrl_if #(.N_IN(4)) ifb ();

    tt_scan_ctrl #(.N_IN(4), .SETTLE(1)) dut_a (.clk(clk), .rst(rst), .scan_if(ifa));
    tt_scan_ctrl #(.N_IN(4), .SETTLE(3)) dut_b (.clk(clk), .rst(rst), .scan_if(ifb));

    function automatic logic f_ref(input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        return (~c & d) | (b & d) | (a & ~b);
    endfunction

    function automatic int ones_of(input logic [15:0] t);
        int n;
        n = 0;
        for (int i = 0; i < 16; i++) if (t[i]) n++;
        return n;
    endfunction

    logic [15:0] fn_tt;
    assign ifa.f_in = f_ref(ifa.vec);
    assign ifb.f_in = fn_tt[ifb.vec];

    int sel = 0;
    logic [3:0]  o_vec;
    logic        o_busy, o_done, o_match;
    logic [15:0] o_tab;
    logic [4:0]  o_ones;
    assign o_vec  = (sel == 1) ? ifb.vec        : ifa.vec;
    assign o_busy = (sel == 1) ? ifb.busy       : ifa.busy;
    assign o_done = (sel == 1) ? ifb.done       : ifa.done;
    assign o_match= (sel == 1) ? ifb.match      : ifa.match;
    assign o_tab  = (sel == 1) ? ifb.table_out  : ifa.table_out;
    assign o_ones = (sel == 1) ? ifb.ones_count : ifa.ones_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input int s, input logic v);
        if (s == 1) ifb.start = v;
        else        ifa.start = v;
    endtask

    task automatic set_exp(input int s, input logic [15:0] v);
        if (s == 1) ifb.expected = v;
        else        ifa.expected = v;
    endtask

    task automatic chk_zero(input int s, input string tag);
        sel = s;
        #1;
        chk({tag, "_vec"},   o_vec,   0);
        chk({tag, "_busy"},  o_busy,  0);
        chk({tag, "_done"},  o_done,  0);
        chk({tag, "_table"}, o_tab,   0);
        chk({tag, "_match"}, o_match, 0);
        chk({tag, "_ones"},  o_ones,  0);
    endtask

    // One complete scan; each vector occupies SETTLE+1 cycles (hold plus sample).
    task automatic scan(input int s, input logic [15:0] exp, input logic [15:0] tt, input bit disturb);
        int p, t, m;
        sel = s;
        p = (s == 1) ? 4 : 2;
        t = 16 * p;
        m = (tt == exp) ? 1 : 0;
        set_exp(s, exp);
        set_start(s, 1'b1);
        tick();
        set_start(s, 1'b0);
        for (int cyc = 1; cyc <= t + 3; cyc++) begin
            if (cyc <= t) begin
                chk("scan_vec",  o_vec,  (cyc - 1) / p);
                chk("scan_busy", o_busy, 1);
                chk("scan_done_early", o_done, 0);
            end else if (cyc == t + 1) begin
                chk("done_pulse", o_done, 1);
                chk("done_busy",  o_busy, 1);
                chk("done_table", o_tab,  tt);
                chk("done_match", o_match, m);
                chk("done_ones",  o_ones, ones_of(tt));
            end else begin
                chk("post_done",  o_done, 0);
                chk("post_busy",  o_busy, 0);
                chk("post_vec",   o_vec,  0);
                chk("held_table", o_tab,  tt);
                chk("held_match", o_match, m);
                chk("held_ones",  o_ones, ones_of(tt));
            end
            if (disturb) begin
                if (cyc == 3 * p + 1) begin
                    set_start(s, 1'b1);
                    set_exp(s, ~exp);
                end else if (cyc == t + 1) begin
                    set_start(s, 1'b1);
                end else begin
                    set_start(s, 1'b0);
                end
            end
            tick();
        end
        set_start(s, 1'b0);
    endtask

    logic [15:0] tt_a;
    logic [15:0] rexp;

    initial begin
        rst          = 1'b1;
        ifa.start    = 1'b0;
        ifb.start    = 1'b0;
        ifa.expected = '0;
        ifb.expected = '0;
        fn_tt        = '0;
        for (int k = 0; k < 16; k++) tt_a[k] = f_ref(4'(k));

        // Reset held with start pulsed: nothing may leave reset values.
        tick();
        ifa.start = 1'b1;
        ifb.start = 1'b1;
        ifa.expected = 16'hFFFF;
        tick();
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        chk_zero(0, "rst_a");
        chk_zero(1, "rst_b");
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk_zero(0, "idle_a");
        chk_zero(1, "idle_b");

        scan(0, 16'hAFA2, tt_a, 1'b0);
        scan(0, 16'hAFA3, tt_a, 1'b0);
        scan(0, 16'hAFA2, tt_a, 1'b1);

        // Reset in the middle of a scan while vec==7.
        sel = 0;
        ifa.expected = 16'hAFA2;
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        for (int cyc = 1; cyc < 15; cyc++) tick();
        chk("mid_vec7", o_vec, 7);
        rst = 1'b1;
        chk_zero(0, "midrst");
        tick();
        tick();
        chk("midrst_done", o_done, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("after_rst_done", o_done, 0);
            chk("after_rst_busy", o_busy, 0);
        end
        scan(0, 16'hAFA2, tt_a, 1'b0);

        fn_tt = 16'hFFFF;
        scan(1, 16'hFFFF, 16'hFFFF, 1'b0);

        for (int r = 0; r < 4; r++) begin
            fn_tt = 16'($urandom);
            rexp  = ($urandom_range(0, 1) == 1) ? fn_tt : 16'($urandom);
            repeat ($urandom_range(0, 3)) tick();
            scan(1, rexp, fn_tt, 1'($urandom_range(0, 1)));
            rexp  = ($urandom_range(0, 1) == 1) ? tt_a : (tt_a ^ 16'(1 << $urandom_range(0, 15)));
            repeat ($urandom_range(0, 3)) tick();
            scan(0, rexp, tt_a, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
